// File: rtl/extremum_collector.sv
// Keypoint collector: tracks raster coordinates of comparator beats, qualifies
// local maxima by contrast and border, and queues keypoints for the descriptor stage.
module extremum_collector #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned IMG_WIDTH   = 640,
    parameter int unsigned IMG_HEIGHT  = 480,
    parameter int unsigned COORD_WIDTH = 11,
    parameter int unsigned BORDER      = 1,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          din_valid,
    input  logic                          sof,
    input  logic signed [DATA_WIDTH-1:0]  center_response,
    input  logic                          max_flag,
    input  logic signed [DATA_WIDTH-1:0]  threshold,
    output logic                          kp_valid,
    input  logic                          kp_ready,
    output logic [COORD_WIDTH-1:0]        kp_x,
    output logic [COORD_WIDTH-1:0]        kp_y,
    output logic signed [DATA_WIDTH-1:0]  kp_response,
    output logic [15:0]                   kp_count,
    output logic                          overflow,
    output logic                          frame_done
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = 2 * COORD_WIDTH + DATA_WIDTH;

    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(IMG_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [COORD_WIDTH-1:0] X_LO   = COORD_WIDTH'(BORDER);
    localparam logic [COORD_WIDTH-1:0] X_HI   = COORD_WIDTH'(IMG_WIDTH - 1 - BORDER);
    localparam logic [COORD_WIDTH-1:0] Y_LO   = COORD_WIDTH'(BORDER);
    localparam logic [COORD_WIDTH-1:0] Y_HI   = COORD_WIDTH'(IMG_HEIGHT - 1 - BORDER);

    logic [COORD_WIDTH-1:0] x_cnt;
    logic [COORD_WIDTH-1:0] y_cnt;
    logic [COORD_WIDTH-1:0] bx_c;
    logic [COORD_WIDTH-1:0] by_c;
    logic                   in_window_c;
    logic                   qualify_c;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt_c;
    logic [PW-1:0] rd_ptr_nxt_c;
    logic          full_c;
    logic          pop_c;
    logic          push_c;
    logic          drop_c;
    logic [EW-1:0] entry_c;
    logic [EW-1:0] head_c;

    // A start-of-frame beat is pixel (0,0) whatever the counters hold
    assign bx_c = sof ? '0 : x_cnt;
    assign by_c = sof ? '0 : y_cnt;

    assign in_window_c = (bx_c >= X_LO) && (bx_c <= X_HI) && (by_c >= Y_LO) && (by_c <= Y_HI);
    assign qualify_c   = din_valid && max_flag && (center_response > threshold) && in_window_c;

    assign full_c = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_c  = kp_valid && kp_ready;
    assign push_c = qualify_c && (!full_c || pop_c);
    assign drop_c = qualify_c && full_c && !pop_c;

    assign wr_ptr_nxt_c = wr_ptr + PW'(push_c);
    assign rd_ptr_nxt_c = rd_ptr + PW'(pop_c);
    assign entry_c      = {bx_c, by_c, center_response};

    // Next head: bypass the entry being written when it lands at the new read slot
    always_comb begin
        head_c = mem[rd_ptr_nxt_c[AW-1:0]];
        if (push_c && (rd_ptr_nxt_c == wr_ptr)) begin
            head_c = entry_c;
        end
    end

    // Raster coordinate tracking and end-of-frame pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (din_valid) begin
                if (bx_c == X_LAST) begin
                    x_cnt <= '0;
                    if (by_c == Y_LAST) begin
                        y_cnt      <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        y_cnt <= by_c + 1'b1;
                    end
                end else begin
                    x_cnt <= bx_c + 1'b1;
                    y_cnt <= by_c;
                end
            end
        end
    end

    // Per-frame keypoint count (saturating) and sticky drop flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kp_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (din_valid && sof) begin
                kp_count <= qualify_c ? 16'd1 : 16'd0;
            end else if (qualify_c && (kp_count != 16'hFFFF)) begin
                kp_count <= kp_count + 16'd1;
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr[AW-1:0]] <= entry_c;
        end
    end

    // FIFO pointers and registered head presentation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            kp_valid    <= 1'b0;
            kp_x        <= '0;
            kp_y        <= '0;
            kp_response <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nxt_c;
            rd_ptr   <= rd_ptr_nxt_c;
            kp_valid <= (wr_ptr_nxt_c != rd_ptr_nxt_c);
            if (wr_ptr_nxt_c != rd_ptr_nxt_c) begin
                {kp_x, kp_y, kp_response} <= head_c;
            end
        end
    end

endmodule

// File: tb/tb_extremum_collector.sv
// Directed bench for extremum_collector on an 8x4 frame with a 4-entry FIFO.
module tb_extremum_collector;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [31:0] r;
    } kp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               din_valid;
    logic               sof;
    logic signed [31:0] center_response;
    logic               max_flag;
    logic signed [31:0] threshold;
    logic               kp_valid;
    logic               kp_ready;
    logic [10:0]        kp_x;
    logic [10:0]        kp_y;
    logic signed [31:0] kp_response;
    logic [15:0]        kp_count;
    logic               overflow;
    logic               frame_done;

    kp_t                cap[$];
    int                 fd_count = 0;
    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic signed [31:0] resp_map [NPIX];
    bit                 flag_map [NPIX];

    extremum_collector #(
        .DATA_WIDTH(32), .IMG_WIDTH(W), .IMG_HEIGHT(H),
        .COORD_WIDTH(11), .BORDER(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .sof(sof),
        .center_response(center_response), .max_flag(max_flag), .threshold(threshold),
        .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_x(kp_x), .kp_y(kp_y),
        .kp_response(kp_response), .kp_count(kp_count), .overflow(overflow),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Record every handshake and every frame_done pulse mid-cycle
    always @(negedge clk) begin
        if (rst_n && kp_valid && kp_ready) cap.push_back({kp_x, kp_y, kp_response});
        if (frame_done) fd_count++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input bit s, input logic signed [31:0] r, input bit f);
        din_valid = 1'b1; sof = s; center_response = r; max_flag = f;
        step();
        din_valid = 1'b0; sof = 1'b0; center_response = '0; max_flag = 1'b0;
    endtask

    task automatic clear_maps();
        for (int i = 0; i < NPIX; i++) begin
            resp_map[i] = '0;
            flag_map[i] = 1'b0;
        end
    endtask

    task automatic set_px(input int x, input int y, input int r);
        resp_map[y*W+x] = r;
        flag_map[y*W+x] = 1'b1;
    endtask

    task automatic run_frame(input bit use_sof);
        for (int i = 0; i < NPIX; i++) send_pixel(use_sof && (i == 0), resp_map[i], flag_map[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_checks++; if (kp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_kp_valid: got %0d expected 0", kp_valid); end
        n_checks++; if (kp_x !== 11'd0) begin n_fail++; $display("FAIL rst_kp_x: got %0d expected 0", kp_x); end
        n_checks++; if (kp_y !== 11'd0) begin n_fail++; $display("FAIL rst_kp_y: got %0d expected 0", kp_y); end
        n_checks++; if (kp_response !== 32'sd0) begin n_fail++; $display("FAIL rst_kp_response: got %0d expected 0", kp_response); end
        n_checks++; if (kp_count !== 16'd0) begin n_fail++; $display("FAIL rst_kp_count: got %0d expected 0", kp_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0d expected 0", overflow); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %0d expected 0", frame_done); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_frame();
        int  base, fd0;
        kp_t e;
        threshold = 100; kp_ready = 1'b1;
        clear_maps(); set_px(3, 2, 150); set_px(5, 1, 100);
        base = cap.size(); fd0 = fd_count;
        run_frame(1'b1);
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL basic_fd_high: got %0d expected 1", frame_done); end
        step();
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL basic_fd_low: got %0d expected 0", frame_done); end
        step(); step();
        e.x = 11'd3; e.y = 11'd2; e.r = 32'd150;
        n_checks++; if (cap.size() - base != 1) begin n_fail++; $display("FAIL basic_kp_num: got %0d expected 1", cap.size() - base); end
        if (cap.size() > base) begin
            n_checks++; if (cap[base] !== e) begin n_fail++; $display("FAIL basic_kp: got %0d,%0d,%0d expected 3,2,150", cap[base].x, cap[base].y, $signed(cap[base].r)); end
        end
        n_checks++; if (kp_count !== 16'd1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", kp_count); end
        n_checks++; if (fd_count - fd0 != 1) begin n_fail++; $display("FAIL basic_fd_num: got %0d expected 1", fd_count - fd0); end
    endtask

    task automatic test_border();
        int  base;
        kp_t e;
        threshold = 100; kp_ready = 1'b1;
        clear_maps(); set_px(0, 0, 500); set_px(7, 3, 500); set_px(0, 2, 500); set_px(6, 1, 500);
        base = cap.size();
        run_frame(1'b1);
        step(); step(); step();
        e.x = 11'd6; e.y = 11'd1; e.r = 32'd500;
        n_checks++; if (cap.size() - base != 1) begin n_fail++; $display("FAIL border_kp_num: got %0d expected 1", cap.size() - base); end
        if (cap.size() > base) begin
            n_checks++; if (cap[base] !== e) begin n_fail++; $display("FAIL border_kp: got %0d,%0d,%0d expected 6,1,500", cap[base].x, cap[base].y, $signed(cap[base].r)); end
        end
        n_checks++; if (kp_count !== 16'd1) begin n_fail++; $display("FAIL border_count: got %0d expected 1", kp_count); end
    endtask

    task automatic test_negative();
        int  base;
        kp_t e;
        threshold = -50; kp_ready = 1'b1;
        clear_maps(); set_px(2, 1, -20); set_px(4, 2, -50);
        base = cap.size();
        run_frame(1'b1);
        step(); step(); step();
        e.x = 11'd2; e.y = 11'd1; e.r = -32'sd20;
        n_checks++; if (cap.size() - base != 1) begin n_fail++; $display("FAIL neg_kp_num: got %0d expected 1", cap.size() - base); end
        if (cap.size() > base) begin
            n_checks++; if (cap[base] !== e) begin n_fail++; $display("FAIL neg_kp: got %0d,%0d,%0d expected 2,1,-20", cap[base].x, cap[base].y, $signed(cap[base].r)); end
        end
        n_checks++; if (kp_count !== 16'd1) begin n_fail++; $display("FAIL neg_count: got %0d expected 1", kp_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        threshold = 100; kp_ready = 1'b0;
        clear_maps();
        for (int i = 1; i <= 6; i++) set_px(i, 1, 200 + i);
        run_frame(1'b1);
        step();
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0d expected 1", overflow); end
        n_checks++; if (kp_count !== 16'd6) begin n_fail++; $display("FAIL ovf_count: got %0d expected 6", kp_count); end
        step(); step(); step();
        n_checks++; if (kp_valid !== 1'b1 || kp_x !== 11'd1 || kp_y !== 11'd1 || kp_response !== 32'sd201) begin
            n_fail++; $display("FAIL ovf_stall_head: got v%0d %0d,%0d,%0d expected v1 1,1,201", kp_valid, kp_x, kp_y, kp_response); end
        kp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (kp_valid !== 1'b1 || kp_x !== 11'(1 + i) || kp_y !== 11'd1 || kp_response !== 32'(201 + i)) begin
                n_fail++; $display("FAIL ovf_drain%0d: got v%0d %0d,%0d,%0d expected v1 %0d,1,%0d", i, kp_valid, kp_x, kp_y, kp_response, 1 + i, 201 + i); end
            step();
        end
        n_checks++; if (kp_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %0d expected 0", kp_valid); end
        kp_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        do_reset();
        threshold = 100; kp_ready = 1'b0;
        send_pixel(1'b1, 0, 1'b0);
        for (int i = 1; i < 9; i++) send_pixel(1'b0, 0, 1'b0);
        for (int x = 1; x <= 4; x++) send_pixel(1'b0, 300 + x, 1'b1);
        kp_ready = 1'b1;
        send_pixel(1'b0, 305, 1'b1);
        kp_ready = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %0d expected 0", overflow); end
        n_checks++; if (kp_x !== 11'd2 || kp_y !== 11'd1 || kp_response !== 32'sd302) begin
            n_fail++; $display("FAIL fullpop_head: got %0d,%0d,%0d expected 2,1,302", kp_x, kp_y, kp_response); end
        send_pixel(1'b0, 306, 1'b1);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fullpop_still_full: got %0d expected 1", overflow); end
        kp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (kp_valid !== 1'b1 || kp_x !== 11'(2 + i) || kp_y !== 11'd1 || kp_response !== 32'(302 + i)) begin
                n_fail++; $display("FAIL fullpop_drain%0d: got v%0d %0d,%0d,%0d expected v1 %0d,1,%0d", i, kp_valid, kp_x, kp_y, kp_response, 2 + i, 302 + i); end
            step();
        end
        n_checks++; if (kp_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty: got %0d expected 0", kp_valid); end
        kp_ready = 1'b0;
    endtask

    task automatic test_mid_sof();
        int  base, fd0;
        kp_t e;
        do_reset();
        threshold = 100; kp_ready = 1'b1;
        base = cap.size(); fd0 = fd_count;
        send_pixel(1'b1, 0, 1'b0);
        for (int i = 1; i <= 20; i++) send_pixel(1'b0, (i == 10 || i == 11) ? 400 : 0, (i == 10 || i == 11));
        n_checks++; if (kp_count !== 16'd2) begin n_fail++; $display("FAIL midsof_old_count: got %0d expected 2", kp_count); end
        clear_maps(); set_px(1, 1, 410);
        run_frame(1'b1);
        step(); step();
        e.x = 11'd1; e.y = 11'd1; e.r = 32'd410;
        n_checks++; if (fd_count - fd0 != 1) begin n_fail++; $display("FAIL midsof_fd_num: got %0d expected 1", fd_count - fd0); end
        n_checks++; if (cap.size() - base != 3) begin n_fail++; $display("FAIL midsof_kp_num: got %0d expected 3", cap.size() - base); end
        if (cap.size() > base + 2) begin
            n_checks++; if (cap[base+2] !== e) begin n_fail++; $display("FAIL midsof_kp: got %0d,%0d,%0d expected 1,1,410", cap[base+2].x, cap[base+2].y, $signed(cap[base+2].r)); end
        end
        n_checks++; if (kp_count !== 16'd1) begin n_fail++; $display("FAIL midsof_count: got %0d expected 1", kp_count); end
    endtask

    task automatic test_reset_mid();
        int  base, fd0;
        kp_t e;
        threshold = 100; kp_ready = 1'b0;
        send_pixel(1'b1, 0, 1'b0);
        for (int i = 1; i <= 12; i++) send_pixel(1'b0, (i >= 9 && i <= 11) ? 500 : 0, (i >= 9 && i <= 11));
        n_checks++; if (kp_valid !== 1'b1 || kp_count !== 16'd3) begin n_fail++; $display("FAIL rstmid_pre: got v%0d cnt%0d expected v1 cnt3", kp_valid, kp_count); end
        rst_n = 1'b0;
        step();
        n_checks++; if (kp_valid !== 1'b0 || kp_x !== 11'd0 || kp_y !== 11'd0 || kp_response !== 32'sd0 ||
                         kp_count !== 16'd0 || overflow !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_outputs: got v%0d %0d,%0d,%0d cnt%0d ovf%0d fd%0d expected all 0",
                               kp_valid, kp_x, kp_y, kp_response, kp_count, overflow, frame_done); end
        rst_n = 1'b1;
        kp_ready = 1'b1;
        base = cap.size(); fd0 = fd_count;
        clear_maps(); set_px(3, 2, 150);
        run_frame(1'b0);
        step(); step(); step();
        e.x = 11'd3; e.y = 11'd2; e.r = 32'd150;
        n_checks++; if (cap.size() - base != 1) begin n_fail++; $display("FAIL rstmid_kp_num: got %0d expected 1", cap.size() - base); end
        if (cap.size() > base) begin
            n_checks++; if (cap[base] !== e) begin n_fail++; $display("FAIL rstmid_kp: got %0d,%0d,%0d expected 3,2,150", cap[base].x, cap[base].y, $signed(cap[base].r)); end
        end
        n_checks++; if (fd_count - fd0 != 1) begin n_fail++; $display("FAIL rstmid_fd_num: got %0d expected 1", fd_count - fd0); end
    endtask

    initial begin
        rst_n = 1'b0; din_valid = 1'b0; sof = 1'b0; center_response = '0;
        max_flag = 1'b0; threshold = '0; kp_ready = 1'b0;
        test_reset();
        test_basic_frame();
        test_border();
        test_negative();
        test_overflow();
        test_full_pop();
        test_mid_sof();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/extremum_collector.md
# extremum_collector

Sits directly downstream of the 3×3×3 extremum comparator in the DETDES detector pipeline and consumes its per-pixel center response, local-maximum flag and valid strobe. Tracks raster coordinates for each valid beat and qualifies candidates. A candidate is qualified by an `max_flag`, a strict contrast threshold and border suppression. Qualified keypoints (x, y, response) are buffered in a FIFO and released to the descriptor stage over a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 32: width of signed response.
- `IMG_WIDTH`, 640: pixels per line of the response plane.
- `IMG_HEIGHT`, 480: lines per frame.
- `COORD_WIDTH`, 11: width of x/y coordinates; must hold IMG_WIDTH-1 and IMG_HEIGHT-1.
- `BORDER`, 1: pixels suppressed at each image edge; must be < IMG_WIDTH/2 and < IMG_HEIGHT/2.
- `FIFO_DEPTH`, 16: keypoint FIFO entries; power of two, ≥ 2.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `din_valid` in 1: input beat valid; one beat per pixel, raster order.
- `sof` in 1: start of frame; qualified by `din_valid`, marks the beat as pixel (0,0).
- `center_response` in DATA_WIDTH signed: response of the pixel.
- `max_flag` in 1: comparator's local-maximum flag for the pixel.
- `threshold` in DATA_WIDTH signed: contrast threshold, quasi-static (changes only between frames).
- `kp_valid` out 1: FIFO head holds a keypoint.
- `kp_ready` in 1: consumer accepts head this cycle.
- `kp_x` out COORD_WIDTH: column of head keypoint.
- `kp_y` out COORD_WIDTH: row of head keypoint.
- `kp_response` out DATA_WIDTH signed: response of head keypoint.
- `kp_count` out 16: qualified keypoints in current frame, saturating at 65535.
- `overflow` out 1: sticky; a qualified keypoint was dropped because the FIFO was full.
- `frame_done` out 1: one-cycle pulse after the last pixel of a frame.

## Operation
- Coordinate counters x, y advance only on `din_valid`. The beat's coordinate is (x, y) before the advance.
- `sof && din_valid`: the beat is coordinate (0,0) regardless of counter state; the counters then advance to (1,0); `kp_count` restarts so that this beat counts toward the new frame.
- At x = IMG_WIDTH-1, x wraps to 0 and y increments.
- At the beat (IMG_WIDTH-1, IMG_HEIGHT-1), x and y both wrap to 0 and `frame_done` pulses on the next cycle.
- `sof` arriving mid-frame abandons the old frame silently: no `frame_done` pulse; FIFO contents are kept.
- Qualify condition: `din_valid && max_flag && center_response > threshold` (signed, strict), and the coordinate lies inside the border window:
  - BORDER ≤ x ≤ IMG_WIDTH-1-BORDER
  - BORDER ≤ y ≤ IMG_HEIGHT-1-BORDER
- A qualified beat pushes {x, y, center_response} into the FIFO.
- Push when FIFO is full and `kp_ready` is low: the entry is dropped and `overflow` is set. `overflow` stays set until reset.
- Push when FIFO is full and a pop happens in the same cycle: the push is accepted; no drop.
- `kp_count` increments on every qualified beat, including dropped ones, and saturates.
- Pop occurs when `kp_valid && kp_ready`.
- While `kp_valid && !kp_ready`, `kp_x`, `kp_y` and `kp_response` hold stable.
- FIFO: circular buffer with log2(FIFO_DEPTH)+1-bit read and write pointers. Empty when the pointers are equal; full when the MSBs differ and the other bits are equal.
- `kp_*` are driven from registered storage at the read pointer. There is no combinational path from the inputs to the outputs.
- Reset values: `kp_valid` 0, `kp_x` 0, `kp_y` 0, `kp_response` 0, `kp_count` 0, `overflow` 0, `frame_done` 0. Reset also returns the FIFO to empty and the coordinate counters to (0,0).
- Reset during a frame discards all FIFO entries and in-progress coordinates.

## Timing
- A qualified beat sampled at edge N into an empty FIFO gives `kp_valid` = 1 with its data in the cycle after edge N (latency 1).
- A pop at edge N presents the next entry, or drops `kp_valid`, in the cycle after edge N.
- Sustained throughput: one push and one pop per cycle.
- `kp_count` and `overflow` update in the cycle after the triggering beat.
- `frame_done` is high for exactly the one cycle after the last-pixel beat is sampled.

## Test plan
- Frame with IMG_WIDTH=8, IMG_HEIGHT=4, BORDER=1, threshold=100, `kp_ready` held 1; max_flag set at (3,2) with response 150 and at (5,1) with response 100 → exactly one keypoint (3,2,150); `kp_count`=1; `frame_done` pulses once after beat 31.
- max_flag with response 500 at (0,0), (7,3), (0,2) and (6,1) → only (6,1) emitted; the others are border-suppressed.
- Negative values: threshold=-50, response=-20 with max_flag → emitted; response=-50 → not emitted (strict compare).
- FIFO_DEPTH=4, `kp_ready`=0, 6 qualified beats → 4 entries held and `overflow`=1. Then assert `kp_ready` → entries drain in order, one per cycle, with data stable while stalled; `kp_count`=6.
- FIFO full, pop and qualified push in the same cycle → no overflow and the FIFO stays full. `sof` at pixel (5,2) → the next beat is (0,0) and no `frame_done` is pulsed.
- Assert `rst_n`=0 for one cycle with 3 entries queued → all outputs at reset values in the next cycle; the following frame counts from (0,0).
